// File: rtl/set_bit_enumerator.sv
// Set-bit enumerator: loads a 32-bit word and emits the positions of its set
// bits, lowest first, one per accepted handshake, followed by a one-cycle done.
module set_bit_enumerator (
   input  logic        clock,
   input  logic        reset,
   input  logic        start,
   input  logic [31:0] data_in,
   output logic        ready,
   output logic        out_valid,
   output logic [4:0]  out_index,
   input  logic        out_ready,
   output logic        done,
   output logic        was_zero,
   output logic [5:0]  bit_count,
   output logic [1:0]  fsm_state
);

   // Handshakes: start is taken on a rising edge only when ready=1.
   // An index transfers on a rising edge where out_valid=1 and out_ready=1;
   // while out_ready=0, out_valid and out_index stay stable.

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SCAN = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t      state;
   state_t      state_next;
   logic [31:0] work;
   logic [31:0] work_next;
   logic [5:0]  count;
   logic [5:0]  count_next;
   logic        zero_flag;
   logic        zero_flag_next;
   logic [4:0]  low_index;

   // Descending scan so the lowest set bit wins; yields 0 for an empty word.
   always_comb begin : priority_encode
      low_index = 5'd0;
      for (int i = 31; i >= 0; i--) begin
         if (work[i]) low_index = 5'(i);
      end
   end

   always_comb begin : next_state_logic
      state_next     = state;
      work_next      = work;
      count_next     = count;
      zero_flag_next = zero_flag;
      case (state)
         IDLE: begin
            if (start) begin
               work_next      = data_in;
               count_next     = 6'd0;
               zero_flag_next = (data_in == 32'd0);
               state_next     = (data_in == 32'd0) ? DONE : SCAN;
            end
         end
         SCAN: begin
            if (out_ready) begin
               // work & (work - 1) clears exactly the lowest set bit.
               work_next  = work & (work - 32'd1);
               count_next = (count == 6'd32) ? count : count + 6'd1;
               if (work_next == 32'd0) state_next = DONE;
            end
         end
         DONE: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin : state_register
      if (reset) begin
         state     <= IDLE;
         work      <= 32'd0;
         count     <= 6'd0;
         zero_flag <= 1'b0;
      end else begin
         state     <= state_next;
         work      <= work_next;
         count     <= count_next;
         zero_flag <= zero_flag_next;
      end
   end

   assign ready     = (state == IDLE);
   assign out_valid = (state == SCAN);
   assign done      = (state == DONE);
   assign out_index = low_index;
   assign was_zero  = zero_flag;
   assign bit_count = count;
   assign fsm_state = state;

endmodule

// File: tb/tb_set_bit_enumerator.sv
// Self-checking bench for set_bit_enumerator: directed scenarios plus random
// words with random backpressure, checked against a bit-list reference model.
module tb_set_bit_enumerator;

   logic        clock;
   logic        reset;
   logic        start;
   logic [31:0] data_in;
   logic        ready;
   logic        out_valid;
   logic [4:0]  out_index;
   logic        out_ready;
   logic        done;
   logic        was_zero;
   logic [5:0]  bit_count;
   logic [1:0]  fsm_state;

   int tests = 0;
   int fails = 0;

   logic [4:0] exp_q[$];

   set_bit_enumerator dut (
      .clock     (clock),
      .reset     (reset),
      .start     (start),
      .data_in   (data_in),
      .ready     (ready),
      .out_valid (out_valid),
      .out_index (out_index),
      .out_ready (out_ready),
      .done      (done),
      .was_zero  (was_zero),
      .bit_count (bit_count),
      .fsm_state (fsm_state)
   );

   // clock / reset
   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Reference model: list of set-bit positions, ascending.
   task automatic model_load(input logic [31:0] w);
      exp_q.delete();
      for (int i = 0; i < 32; i++) begin
         if (w[i]) exp_q.push_back(5'(i));
      end
   endtask

   // Loads w, consumes indices with stall_pct% backpressure and checks every
   // cycle through done and the following idle cycle.
   task automatic run_word(input logic [31:0] w, input int stall_pct, input bit inject_start,
                           output int valid_cycles);
      int accepted;
      int total;
      bit finished;
      bit injected;
      model_load(w);
      total = exp_q.size();
      accepted = 0;
      valid_cycles = 0;
      finished = 0;
      injected = 0;
      @(negedge clock);
      tests++;
      if (ready !== 1'b1) begin
         fails++;
         $display("FAIL load_ready: ready=%0b required 1", ready);
      end
      start = 1'b1;
      data_in = w;
      out_ready = 1'b0;
      @(negedge clock);
      start = 1'b0;
      for (int cyc = 0; cyc < 200 && !finished; cyc++) begin
         if (cyc > 0) @(negedge clock);
         start = 1'b0;
         tests++;
         if ($countones({ready, out_valid, done}) != 1) begin
            fails++;
            $display("FAIL exclusive: ready=%0b out_valid=%0b done=%0b required exactly one",
                     ready, out_valid, done);
         end
         if (out_valid === 1'b1) begin
            valid_cycles++;
            tests++;
            if (exp_q.size() == 0) begin
               fails++;
               $display("FAIL extra_index: out_index=%0d required no more indices", out_index);
            end else if (out_index !== exp_q[0] || bit_count !== 6'(accepted)) begin
               fails++;
               $display("FAIL index: out_index=%0d bit_count=%0d required %0d / %0d",
                        out_index, bit_count, exp_q[0], accepted);
            end
            out_ready = ($urandom_range(99) >= stall_pct);
            if (out_ready && exp_q.size() > 0) begin
               void'(exp_q.pop_front());
               accepted++;
            end
            if (inject_start && !injected) begin
               start = 1'b1;
               data_in = ~w;
               injected = 1;
            end
         end else if (done === 1'b1) begin
            finished = 1;
            out_ready = 1'b0;
            tests++;
            if (exp_q.size() != 0 || bit_count !== 6'(total) || was_zero !== (w == 32'd0)) begin
               fails++;
               $display("FAIL done: left=%0d bit_count=%0d was_zero=%0b required 0 / %0d / %0b",
                        exp_q.size(), bit_count, was_zero, total, (w == 32'd0));
            end
         end
      end
      if (!finished) begin
         tests++;
         fails++;
         $display("FAIL timeout: no done for word %h", w);
      end
      @(negedge clock);
      tests++;
      if (ready !== 1'b1 || done !== 1'b0 || bit_count !== 6'(total) || was_zero !== (w == 32'd0)) begin
         fails++;
         $display("FAIL after_done: ready=%0b done=%0b bit_count=%0d was_zero=%0b required 1/0/%0d/%0b",
                  ready, done, bit_count, was_zero, total, (w == 32'd0));
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      start = 1'b0;
      data_in = 32'd0;
      out_ready = 1'b0;
      #1;
      tests++;
      if (ready !== 1'b1 || out_valid !== 1'b0 || out_index !== 5'd0 || done !== 1'b0 ||
          was_zero !== 1'b0 || bit_count !== 6'd0) begin
         fails++;
         $display("FAIL reset: rdy=%0b ov=%0b idx=%0d done=%0b wz=%0b cnt=%0d required 1/0/0/0/0/0",
                  ready, out_valid, out_index, done, was_zero, bit_count);
      end
      repeat (2) @(negedge clock);
      reset = 1'b0;
   endtask

   task automatic test_zero();
      int vc;
      run_word(32'h0000_0000, 0, 0, vc);
      tests++;
      if (vc != 0) begin
         fails++;
         $display("FAIL zero_valid: out_valid cycles=%0d required 0", vc);
      end
   endtask

   task automatic test_sparse();
      int vc;
      run_word(32'h8000_0005, 0, 0, vc);
      tests++;
      if (vc != 3) begin
         fails++;
         $display("FAIL sparse_cycles: out_valid cycles=%0d required 3", vc);
      end
   endtask

   task automatic test_full();
      int vc;
      run_word(32'hFFFF_FFFF, 0, 0, vc);
      tests++;
      if (vc != 32) begin
         fails++;
         $display("FAIL full_cycles: out_valid cycles=%0d required 32", vc);
      end
   endtask

   task automatic test_backpressure();
      logic [4:0] exp_idx[6] = '{5'd4, 5'd4, 5'd4, 5'd4, 5'd8, 5'd0};
      logic       rdy_seq[6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
      @(negedge clock);
      start = 1'b1;
      data_in = 32'h0000_0110;
      out_ready = 1'b0;
      for (int c = 0; c < 6; c++) begin
         @(negedge clock);
         start = 1'b0;
         tests++;
         if (c < 5) begin
            if (out_valid !== 1'b1 || out_index !== exp_idx[c]) begin
               fails++;
               $display("FAIL backpressure_%0d: out_valid=%0b out_index=%0d required 1 / %0d",
                        c, out_valid, out_index, exp_idx[c]);
            end
         end else if (done !== 1'b1 || bit_count !== 6'd2) begin
            fails++;
            $display("FAIL backpressure_done: done=%0b bit_count=%0d required 1 / 2", done, bit_count);
         end
         out_ready = rdy_seq[c];
      end
      @(negedge clock);
   endtask

   task automatic test_start_ignored();
      int vc;
      run_word(32'h0000_1248, 20, 1, vc);
      tests++;
      if (vc < 4) begin
         fails++;
         $display("FAIL ignore_start: out_valid cycles=%0d required at least 4", vc);
      end
   endtask

   task automatic test_async_reset();
      int vc;
      @(negedge clock);
      start = 1'b1;
      data_in = 32'h0000_00F0;
      out_ready = 1'b1;
      @(negedge clock);
      start = 1'b0;
      repeat (2) @(posedge clock);
      #2;
      reset = 1'b1;
      #1;
      tests++;
      if (ready !== 1'b1 || out_valid !== 1'b0 || bit_count !== 6'd0 || out_index !== 5'd0 ||
          done !== 1'b0) begin
         fails++;
         $display("FAIL async_reset: rdy=%0b ov=%0b cnt=%0d idx=%0d done=%0b required 1/0/0/0/0",
                  ready, out_valid, bit_count, out_index, done);
      end
      for (int c = 0; c < 3; c++) begin
         @(negedge clock);
         tests++;
         if (done !== 1'b0 || ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_hold: done=%0b ready=%0b required 0 / 1", done, ready);
         end
      end
      reset = 1'b0;
      out_ready = 1'b0;
      run_word(32'h0000_00F0, 0, 0, vc);
      tests++;
      if (vc != 4) begin
         fails++;
         $display("FAIL post_reset: out_valid cycles=%0d required 4", vc);
      end
   endtask

   task automatic test_random();
      int vc;
      logic [31:0] w;
      for (int n = 0; n < 25; n++) begin
         case ($urandom_range(3))
            0: w = $urandom() & $urandom() & $urandom();
            1: w = 32'd1 << $urandom_range(31);
            default: w = $urandom();
         endcase
         run_word(w, $urandom_range(50), $urandom_range(1), vc);
      end
   endtask

   initial begin
      test_reset();
      test_zero();
      test_sparse();
      test_full();
      test_backpressure();
      test_start_ignored();
      test_async_reset();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
